// File: rtl/i2c_reg_ctrl.sv
// I2C slave write-side register controller: pointer byte after START,
// then auto-incrementing writes into an 8-bit register bank.
module i2c_reg_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int PTR_W    = 4,
  parameter bit WRAP     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_DATA,
    S_DROP
  } state_e;

  localparam logic [8:0]       NUM9 = 9'(NUM_REGS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REGS - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             dv_q, dv_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       regs_d [NUM_REGS];
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             err_q, err_d;
  logic             byte_ev;

  assign dv_d    = data_valid_i;
  assign byte_ev = data_valid_i & ~dv_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    // a new error in the same cycle as err_clr overrides the clear
    err_d       = err_q & ~err_clr;
    if (start_i) begin
      state_d = S_PTR;
    end else if (stop_i) begin
      state_d = S_IDLE;
    end else if (byte_ev) begin
      unique case (state_q)
        S_PTR: begin
          if ({1'b0, data_i} < NUM9) begin
            ptr_d   = data_i[PTR_W-1:0];
            state_d = S_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end
        end
        S_DATA: begin
          regs_d[ptr_q] = data_i;
          wr_strobe_d   = 1'b1;
          wr_addr_d     = ptr_q;
          wr_data_d     = data_i;
          if (ptr_q == LAST) begin
            if (WRAP) ptr_d = '0;
            else      state_d = S_DROP;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
        S_DROP: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      dv_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dv_q        <= dv_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      regs_q      <= regs_d;
    end
  end

  assign rd_data   = (9'(rd_addr) < NUM9) ? regs_q[rd_addr] : 8'h00;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: a WRAP=1 and a WRAP=0 instance share stimulus
// and are compared against a transaction-level register model.
module tb_i2c_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       data_valid_i = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic       err_clr = 1'b0;

  logic [7:0] rd_data0, rd_data1, wr_data0, wr_data1;
  logic [3:0] wr_addr0, wr_addr1;
  logic       wr_strobe0, wr_strobe1, busy0, busy1, err0, err1;

  i2c_reg_ctrl #(.NUM_REGS(16), .PTR_W(4), .WRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .rd_addr(rd_addr),
    .rd_data(rd_data0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .busy(busy0), .err(err0), .err_clr(err_clr)
  );

  i2c_reg_ctrl #(.NUM_REGS(16), .PTR_W(4), .WRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .rd_addr(rd_addr),
    .rd_data(rd_data1), .wr_strobe(wr_strobe1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .busy(busy1), .err(err1), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model: index 0 = no-wrap instance, index 1 = wrapping instance
  // phase: 0 idle, 1 awaiting pointer, 2 writing, 3 discarding
  int mregs[2][16];
  int mptr[2];
  int mph[2];
  bit merr[2];
  int exq[$], exc[$], gtq[$], gtc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (wr_strobe0) begin
      gtq.push_back((int'(wr_addr0) << 8) | int'(wr_data0));
      gtc.push_back(cyc);
    end
    if (wr_strobe1) begin
      gtq.push_back((1 << 16) | (int'(wr_addr1) << 8) | int'(wr_data1));
      gtc.push_back(cyc);
    end
  end

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) mregs[k][a] = 0;
      mptr[k] = 0;
      mph[k] = 0;
      merr[k] = 1'b0;
    end
  endfunction

  function automatic void m_byte(int b);
    for (int k = 0; k < 2; k++) begin
      if (mph[k] == 1) begin
        if (b < 16) begin mptr[k] = b; mph[k] = 2; end
        else begin merr[k] = 1'b1; mph[k] = 3; end
      end else if (mph[k] == 2) begin
        mregs[k][mptr[k]] = b;
        exq.push_back((k << 16) | (mptr[k] << 8) | b);
        exc.push_back(cyc + 1);
        if (mptr[k] + 1 < 16) mptr[k] = mptr[k] + 1;
        else if (k == 1) mptr[k] = 0;
        else mph[k] = 3;
      end else if (mph[k] == 3) begin
        merr[k] = 1'b1;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    exq.delete(); exc.delete(); gtq.delete(); gtc.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    mph[0] = 1; mph[1] = 1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop_i = 1'b1;
    mph[0] = 0; mph[1] = 0;
    @(negedge clk);
    stop_i = 1'b0;
  endtask

  task automatic send(int b, int hold = 1);
    @(negedge clk);
    data_i = 8'(b);
    data_valid_i = 1'b1;
    m_byte(b);
    repeat (hold) @(negedge clk);
    data_valid_i = 1'b0;
  endtask

  // byte rising together with START or STOP: the byte must be lost
  task automatic ctl_with_byte(bit is_start, int b);
    @(negedge clk);
    data_i = 8'(b);
    data_valid_i = 1'b1;
    start_i = is_start;
    stop_i = ~is_start;
    mph[0] = is_start ? 1 : 0;
    mph[1] = is_start ? 1 : 0;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0; data_valid_i = 1'b0;
  endtask

  task automatic pulse_clr(bit with_byte, int b);
    @(negedge clk);
    err_clr = 1'b1;
    merr[0] = 1'b0; merr[1] = 1'b0;
    if (with_byte) begin
      data_i = 8'(b);
      data_valid_i = 1'b1;
      m_byte(b);
    end
    @(negedge clk);
    err_clr = 1'b0; data_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0 || err0 !== 1'b0 || err1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_status busy=%b%b err=%b%b want 0000", busy0, busy1, err0, err1);
    end
    total++;
    if (wr_strobe0 !== 1'b0 || wr_addr0 !== 4'h0 || wr_data0 !== 8'h00 ||
        wr_strobe1 !== 1'b0 || wr_addr1 !== 4'h0 || wr_data1 !== 8'h00) begin
      bad++;
      $display("FAIL reset_wr got %b/%h/%h %b/%h/%h want zeros", wr_strobe0, wr_addr0,
               wr_data0, wr_strobe1, wr_addr1, wr_data1);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      total++;
      if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin
        bad++;
        $display("FAIL reset_regs a=%0d got %h/%h want 00", a, rd_data0, rd_data1);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    do_start();
    total++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy got %b%b want 11", busy0, busy1);
    end
    send(8'h03); send(8'hA5); send(8'h5A);
    do_stop();
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got %b%b want 00", busy0, busy1);
    end
    total++;
    if (gtq.size() !== 4 || exq.size() !== 4) begin
      bad++;
      $display("FAIL basic_nstrobe got %0d want %0d (4)", gtq.size(), exq.size());
    end
    for (int i = 0; i < gtq.size() && i < exq.size(); i++) begin
      total++;
      if (gtq[i] !== exq[i] || gtc[i] !== exc[i]) begin
        bad++;
        $display("FAIL basic_strobe i=%0d got %h@%0d want %h@%0d", i, gtq[i], gtc[i], exq[i], exc[i]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      total++;
      if (rd_data0 !== 8'(mregs[0][a]) || rd_data1 !== 8'(mregs[1][a])) begin
        bad++;
        $display("FAIL basic_regs a=%0d got %h/%h want %h", a, rd_data0, rd_data1, mregs[1][a]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    do_start();
    send(8'h0F); send(8'h11); send(8'h22);
    do_stop();
    rd_addr = 4'hF; #1;
    total++;
    if (rd_data0 !== 8'h11 || rd_data1 !== 8'h11) begin
      bad++;
      $display("FAIL wrap_r15 got %h/%h want 11/11", rd_data0, rd_data1);
    end
    rd_addr = 4'h0; #1;
    total++;
    if (rd_data0 !== 8'(mregs[0][0]) || rd_data1 !== 8'(mregs[1][0])) begin
      bad++;
      $display("FAIL wrap_r0 got %h/%h want %h/%h", rd_data0, rd_data1, mregs[0][0], mregs[1][0]);
    end
    total++;
    if (err0 !== merr[0] || err1 !== merr[1]) begin
      bad++;
      $display("FAIL wrap_err got %b/%b want %b/%b", err0, err1, merr[0], merr[1]);
    end
    total++;
    if (gtq != exq) begin
      bad++;
      $display("FAIL wrap_strobes got %0d want %0d", gtq.size(), exq.size());
    end
  endtask

  task automatic test_bad_ptr();
    do_reset();
    do_start();
    send(8'h20); send(8'h77);
    total++;
    if (gtq.size() !== 0 || err0 !== 1'b1 || err1 !== 1'b1) begin
      bad++;
      $display("FAIL badptr got n=%0d err=%b%b want n=0 err=11", gtq.size(), err0, err1);
    end
    pulse_clr(1'b1, 8'h55);
    total++;
    if (err0 !== merr[0] || err1 !== merr[1]) begin
      bad++;
      $display("FAIL badptr_setwins got %b%b want %b%b", err0, err1, merr[0], merr[1]);
    end
    pulse_clr(1'b0, 0);
    total++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      bad++;
      $display("FAIL badptr_clr got %b%b want 00", err0, err1);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      total++;
      if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin
        bad++;
        $display("FAIL badptr_regs a=%0d got %h/%h want 00", a, rd_data0, rd_data1);
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    do_start();
    send(8'h02); send(8'hAA);
    do_start();
    send(8'h08); send(8'hBB);
    ctl_with_byte(1'b1, 8'hCC);
    send(8'h05);
    ctl_with_byte(1'b0, 8'hDD);
    total++;
    if (gtq != exq || gtc != exc) begin
      bad++;
      $display("FAIL restart_strobes got %0d want %0d", gtq.size(), exq.size());
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      total++;
      if (rd_data0 !== 8'(mregs[0][a]) || rd_data1 !== 8'(mregs[1][a])) begin
        bad++;
        $display("FAIL restart_regs a=%0d got %h/%h want %h", a, rd_data0, rd_data1, mregs[1][a]);
      end
    end
  endtask

  task automatic test_held_and_idle();
    do_reset();
    do_start();
    send(8'h05);
    send(8'h66, 20);
    do_stop();
    send(8'h01); send(8'h99);
    total++;
    if (gtq.size() !== 2 || gtq != exq) begin
      bad++;
      $display("FAIL held_strobes got %0d want %0d", gtq.size(), exq.size());
    end
    rd_addr = 4'h5; #1;
    total++;
    if (rd_data0 !== 8'h66 || rd_data1 !== 8'h66) begin
      bad++;
      $display("FAIL held_r5 got %h/%h want 66", rd_data0, rd_data1);
    end
    rd_addr = 4'h1; #1;
    total++;
    if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin
      bad++;
      $display("FAIL idle_r1 got %h/%h want 00", rd_data0, rd_data1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_start();
    send(8'h01); send(8'h33);
    do_reset();
    send(8'h44);
    total++;
    if (gtq.size() !== 0 || busy0 !== 1'b0 || busy1 !== 1'b0 || err0 !== 1'b0 || err1 !== 1'b0) begin
      bad++;
      $display("FAIL rstmid got n=%0d busy=%b%b err=%b%b want 0 00 00", gtq.size(),
               busy0, busy1, err0, err1);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      total++;
      if (rd_data0 !== 8'h00 || rd_data1 !== 8'h00) begin
        bad++;
        $display("FAIL rstmid_regs a=%0d got %h/%h want 00", a, rd_data0, rd_data1);
      end
    end
  endtask

  task automatic test_random();
    int n, r;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      do_start();
      send(int'($urandom_range(0, 19)));
      n = int'($urandom_range(0, 18));
      for (int j = 0; j < n; j++) send(int'($urandom_range(0, 255)));
      r = int'($urandom_range(0, 3));
      if (r == 0) ctl_with_byte(1'b0, int'($urandom_range(0, 255)));
      else if (r == 1) do_stop();
      else if (r == 3) begin pulse_clr(1'b0, 0); do_stop(); end
    end
    total++;
    if (gtq != exq || gtc != exc) begin
      bad++;
      $display("FAIL rand_strobes got %0d want %0d", gtq.size(), exq.size());
    end
    total++;
    if (err0 !== merr[0] || err1 !== merr[1]) begin
      bad++;
      $display("FAIL rand_err got %b%b want %b%b", err0, err1, merr[0], merr[1]);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      total++;
      if (rd_data0 !== 8'(mregs[0][a]) || rd_data1 !== 8'(mregs[1][a])) begin
        bad++;
        $display("FAIL rand_regs a=%0d got %h/%h want %h/%h", a, rd_data0, rd_data1,
                 mregs[0][a], mregs[1][a]);
      end
    end
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_bad_ptr();
    test_restart();
    test_held_and_idle();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
Write-side controller for the I2C slave byte receiver. It consumes the receiver's start/stop/data/data_valid outputs, interprets the first byte after each START as a register pointer, and writes subsequent bytes into an internal register bank with pointer auto-increment. It also raises a per-write strobe and sticky error status, and exposes a combinational read port so the rest of the design can use the register values.

Parameters:
NUM_REGS, 16, number of 8-bit registers in the bank (2..256)
PTR_W, 4, pointer width; must satisfy 2**PTR_W >= NUM_REGS
WRAP, 1, 1 = pointer wraps NUM_REGS-1 -> 0; 0 = writes past the last register are dropped and flagged

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_i  in  1  START/repeated-START pulse from the I2C receiver
stop_i  in  1  STOP pulse from the I2C receiver
data_i  in  8  received byte; valid while data_valid_i is high
data_valid_i  in  1  level; a byte event is its 0->1 transition
rd_addr  in  PTR_W  read-port register index
rd_data  out  8  regs[rd_addr], combinational; 8'h00 if rd_addr >= NUM_REGS
wr_strobe  out  1  one-cycle pulse, one per register written
wr_addr  out  PTR_W  index written, valid with wr_strobe
wr_data  out  8  value written, valid with wr_strobe
busy  out  1  high in states PTR, DATA and DROP
err  out  1  sticky error flag
err_clr  in  1  clears err

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-high reset drives:
  - state=IDLE, ptr=0, dv_d=0
  - all regs=8'h00
  - wr_strobe=0, wr_addr=0, wr_data=0, err=0
- Byte event: byte_ev = data_valid_i & ~dv_d, where dv_d is data_valid_i registered each cycle.
  - A level held high for many cycles yields exactly one event.
- States:
  - IDLE: byte_ev is ignored.
    - start_i -> PTR.
  - PTR: on byte_ev:
    - if data_i < NUM_REGS: ptr <= data_i[PTR_W-1:0], -> DATA.
    - else: err <= 1, -> DROP.
  - DATA: on byte_ev: regs[ptr] <= data_i, wr_strobe <= 1, wr_addr <= ptr, wr_data <= data_i.
    - if ptr == NUM_REGS-1 and WRAP=1: ptr <= 0, stay in DATA.
    - if ptr == NUM_REGS-1 and WRAP=0: -> DROP, without setting err.
    - otherwise ptr <= ptr+1.
  - DROP: every byte_ev sets err <= 1 and discards the byte.
    - Covers bad pointers and overflow bytes with WRAP=0.
- Global transitions, in priority order (highest first):
  1. reset
  2. start_i -> PTR, from any state including PTR
  3. stop_i -> IDLE
  4. the per-state byte_ev action
- Simultaneous events:
  - start_i and byte_ev in the same cycle: the byte is discarded and the state goes to PTR.
  - stop_i and byte_ev in the same cycle: the byte is discarded and the state goes to IDLE.
- Latency: byte_ev in cycle N gives the register update, wr_strobe/wr_addr/wr_data, and the updated rd_data (if rd_addr matches) all in cycle N+1. wr_strobe is high for exactly that one cycle.
- Pointer across transactions:
  - ptr persists across STOP.
  - A new transaction always loads ptr from its first byte; there is no read-pointer semantics.
- err:
  - err_clr=1 clears err on the next edge.
  - If err_clr and a new error occur in the same cycle, the set wins (err=1).
- Reset mid-transaction: abandons the transfer; regs return to 0; the next byte is ignored until a START.
- Register contents are modified only by DATA-state writes and by reset.

Test Plan:
1. Basic write: reset; START, bytes 0x03, 0xA5, 0x5A, STOP.
   - regs[3]=0xA5, regs[4]=0x5A, other regs unchanged.
   - Exactly two wr_strobe pulses, (addr 3, 0xA5) then (addr 4, 0x5A), each one cycle after its data_valid rise.
   - busy=0 after STOP.
2. Wrap, WRAP=1: START, pointer 0x0F, data 0x11, 0x22.
   - regs[15]=0x11, regs[0]=0x22, err=0.
   - Repeat with WRAP=0: regs[15]=0x11, regs[0] unchanged, err=1.
3. Bad pointer, NUM_REGS=16: START, pointer 0x20, data 0x77.
   - No wr_strobe, no register changed, err=1.
   - err_clr pulse -> err=0 on the next cycle.
4. Repeated START: START, 0x02, 0xAA, START, 0x08, 0xBB, STOP.
   - regs[2]=0xAA, regs[8]=0xBB, regs[3]=0x00.
   - START asserted in the same cycle as a data_valid rise: that byte is discarded and no strobe is issued.
5. Held valid and no START: data_valid_i held high for 20 cycles in DATA gives one write only. Bytes sent while in IDLE (no START) give no writes.
6. Reset mid-transfer: after START, 0x01, 0x33, assert reset for 1 cycle, then send 0x44 without a START.
   - All regs=0, state IDLE, no wr_strobe, err=0.
